// File: rtl/pipe_reg_id_exe_trk.sv
// ID/EXE pipeline register with valid/flush/stall handling and an in-flight
// tracker for the multi-cycle divide unit.
// All state updates on the falling edge of clk; rst is async active-high.
// Optional feature macro: ID_EXE_PERF_EN (stall performance counter).
module pipe_reg_id_exe_trk #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 4,
  parameter int unsigned FLAGS_W = 6,
  parameter int unsigned UNIT_W  = 4,
  parameter int unsigned DIV_BIT = 0,
  parameter int unsigned DIV_LAT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_allow,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [FLAGS_W-1:0] in_flags,
  input  logic [REG_AW-1:0]  in_rd,
  input  logic [REG_AW-1:0]  in_rs1,
  input  logic [REG_AW-1:0]  in_rs2,
  input  logic [UNIT_W-1:0]  in_unit,
  input  logic [DATA_W-1:0]  in_d1,
  input  logic [DATA_W-1:0]  in_d2,
  input  logic [DATA_W-1:0]  in_imm,
  output logic               out_valid,
  output logic [FLAGS_W-1:0] out_flags,
  output logic [REG_AW-1:0]  out_rd,
  output logic [REG_AW-1:0]  out_rs1,
  output logic [REG_AW-1:0]  out_rs2,
  output logic [UNIT_W-1:0]  out_unit,
  output logic [DATA_W-1:0]  out_d1,
  output logic [DATA_W-1:0]  out_d2,
  output logic [DATA_W-1:0]  out_imm,
  output logic               stall_req,
  output logic               div_busy,
  output logic [REG_AW-1:0]  div_rd,
  output logic               div_done,
  output logic [15:0]        perf_stall_cnt
);

  // Counter is wide enough for the full legal latency range (2..255).
  localparam int unsigned CNT_W = 8;

  logic             is_div;
  logic             cap;
  logic [CNT_W-1:0] div_cnt;
  logic [CNT_W-1:0] div_cnt_nxt;

  // Hazard detection against the outstanding divide, capture qualifier and
  // next divide countdown value.
  always_comb begin
    is_div      = in_valid & in_unit[DIV_BIT];
    stall_req   = in_valid & div_busy &
                  (is_div | (in_rs1 == div_rd) | (in_rs2 == div_rd) | (in_rd == div_rd));
    cap         = wr_allow & ~flush & ~stall_req;
    div_cnt_nxt = div_cnt;
    if (cap && is_div) begin
      div_cnt_nxt = CNT_W'(DIV_LAT);
    end else if (div_cnt != '0) begin
      div_cnt_nxt = div_cnt - CNT_W'(1);
    end
  end

  // Stage register: flush squashes, wr_allow low holds, stall inserts a bubble.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_flags <= '0;
      out_rd    <= '0;
      out_rs1   <= '0;
      out_rs2   <= '0;
      out_unit  <= '0;
      out_d1    <= '0;
      out_d2    <= '0;
      out_imm   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (wr_allow) begin
      if (stall_req) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        out_flags <= in_flags;
        out_rd    <= in_rd;
        out_rs1   <= in_rs1;
        out_rs2   <= in_rs2;
        out_unit  <= in_unit;
        out_d1    <= in_d1;
        out_d2    <= in_d2;
        out_imm   <= in_imm;
      end
    end
  end

  // Divide tracker: countdown runs independent of wr_allow/flush; done pulses
  // for one cycle after the 1->0 transition.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      div_busy <= 1'b0;
      div_rd   <= '0;
      div_done <= 1'b0;
    end else begin
      div_cnt  <= div_cnt_nxt;
      div_busy <= (div_cnt_nxt != '0);
      div_done <= (div_cnt == CNT_W'(1)) && (div_cnt_nxt == '0);
      if (cap && is_div) begin
        div_rd <= in_rd;
      end
    end
  end

`ifdef ID_EXE_PERF_EN
  // Saturating count of edges where the stage wanted to advance but stalled.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
    end else if (wr_allow && !flush && stall_req && (perf_stall_cnt != 16'hFFFF)) begin
      perf_stall_cnt <= perf_stall_cnt + 16'd1;
    end
  end
`else
  assign perf_stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_reg_id_exe_trk.sv
// Self-checking bench for pipe_reg_id_exe_trk: directed scenarios followed by
// randomized traffic, all checked against a cycle-count based reference model.
module tb_pipe_reg_id_exe_trk;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_AW  = 4;
  localparam int unsigned FLAGS_W = 6;
  localparam int unsigned UNIT_W  = 4;
  localparam int unsigned DIV_BIT = 0;
  localparam int          LAT     = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               wr_allow = 1'b0;
  logic               flush = 1'b0;
  logic               in_valid = 1'b0;
  logic [FLAGS_W-1:0] in_flags = '0;
  logic [REG_AW-1:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [UNIT_W-1:0]  in_unit = '0;
  logic [DATA_W-1:0]  in_d1 = '0, in_d2 = '0, in_imm = '0;
  logic               out_valid;
  logic [FLAGS_W-1:0] out_flags;
  logic [REG_AW-1:0]  out_rd, out_rs1, out_rs2;
  logic [UNIT_W-1:0]  out_unit;
  logic [DATA_W-1:0]  out_d1, out_d2, out_imm;
  logic               stall_req, div_busy, div_done;
  logic [REG_AW-1:0]  div_rd;
  logic [15:0]        perf_stall_cnt;

  pipe_reg_id_exe_trk #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .FLAGS_W(FLAGS_W),
    .UNIT_W(UNIT_W), .DIV_BIT(DIV_BIT), .DIV_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .wr_allow(wr_allow), .flush(flush),
    .in_valid(in_valid), .in_flags(in_flags), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_unit(in_unit),
    .in_d1(in_d1), .in_d2(in_d2), .in_imm(in_imm),
    .out_valid(out_valid), .out_flags(out_flags), .out_rd(out_rd),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_unit(out_unit),
    .out_d1(out_d1), .out_d2(out_d2), .out_imm(out_imm),
    .stall_req(stall_req), .div_busy(div_busy), .div_rd(div_rd),
    .div_done(div_done), .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: divide tracked by the edge number at which it started.
  logic               m_valid;
  logic [FLAGS_W-1:0] m_flags;
  logic [REG_AW-1:0]  m_rd, m_rs1, m_rs2, m_drd;
  logic [UNIT_W-1:0]  m_unit;
  logic [DATA_W-1:0]  m_d1, m_d2, m_imm;
  logic               m_act;
  int                 m_s, m_e;
  int                 m_perf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_busy();
    return m_act && ((m_e - m_s) < LAT);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_flags = '0; m_rd = '0; m_rs1 = '0; m_rs2 = '0;
    m_unit = '0; m_d1 = '0; m_d2 = '0; m_imm = '0;
    m_act = 1'b0; m_drd = '0; m_perf = 0;
  endtask

  task automatic check_outputs();
    int exp_perf;
`ifdef ID_EXE_PERF_EN
    exp_perf = m_perf;
`else
    exp_perf = 0;
`endif
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("out_flags", 64'(out_flags), 64'(m_flags));
    check("out_rd",    64'(out_rd),    64'(m_rd));
    check("out_rs1",   64'(out_rs1),   64'(m_rs1));
    check("out_rs2",   64'(out_rs2),   64'(m_rs2));
    check("out_unit",  64'(out_unit),  64'(m_unit));
    check("out_d1",    64'(out_d1),    64'(m_d1));
    check("out_d2",    64'(out_d2),    64'(m_d2));
    check("out_imm",   64'(out_imm),   64'(m_imm));
    check("div_busy",  64'(div_busy),  64'(m_busy()));
    check("div_rd",    64'(div_rd),    64'(m_drd));
    check("div_done",  64'(div_done),  64'(m_act && ((m_e - m_s) == LAT)));
    check("perf_cnt",  64'(perf_stall_cnt), 64'(exp_perf));
  endtask

  // One falling edge: check the combinational stall, advance model, check state.
  task automatic step();
    logic isdiv, stall;
    #1;
    isdiv = in_valid && in_unit[DIV_BIT];
    stall = in_valid && m_busy() &&
            (isdiv || in_rs1 == m_drd || in_rs2 == m_drd || in_rd == m_drd);
    check("stall_req", 64'(stall_req), 64'(stall));
    @(negedge clk);
    m_e++;
    if (wr_allow && !flush && stall && m_perf != 65535) m_perf++;
    if (flush) begin
      m_valid = 1'b0;
    end else if (wr_allow) begin
      if (stall) begin
        m_valid = 1'b0;
      end else begin
        m_valid = in_valid; m_flags = in_flags; m_rd = in_rd;
        m_rs1 = in_rs1; m_rs2 = in_rs2; m_unit = in_unit;
        m_d1 = in_d1; m_d2 = in_d2; m_imm = in_imm;
        if (isdiv) begin
          m_act = 1'b1; m_s = m_e; m_drd = in_rd;
        end
      end
    end
    #1;
    check_outputs();
  endtask

  // Asynchronous reset between edges, held over one edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    m_e++;
    #1;
    check_outputs();
    rst = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [UNIT_W-1:0] u,
                       input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs1,
                       input logic [REG_AW-1:0] rs2);
    in_valid = v; in_unit = u; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_flags = FLAGS_W'($urandom);
    in_d1 = $urandom; in_d2 = $urandom; in_imm = $urandom;
  endtask

  initial begin
    m_e = 0; m_s = 0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Plain load
    wr_allow = 1'b1;
    drive(1'b1, 4'b0010, 4'd3, 4'd1, 4'd2);
    in_d1 = 32'h1234;
    step();
    check("dir_out_rd", 64'(out_rd), 64'd3);
    check("dir_out_d1", 64'(out_d1), 64'h1234);
    check("dir_out_valid", 64'(out_valid), 64'd1);

    // Hold for three edges, then flush
    wr_allow = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'b0100, REG_AW'(i + 9), 4'd4, 4'd5);
      step();
    end
    check("dir_hold_d1", 64'(out_d1), 64'h1234);
    wr_allow = 1'b1; flush = 1'b1;
    step();
    check("dir_flush_valid", 64'(out_valid), 64'd0);
    check("dir_flush_d1", 64'(out_d1), 64'h1234);
    flush = 1'b0;

    // Divide to r5, hazards while it is outstanding, second divide at count 1
    drive(1'b1, 4'b0001, 4'd5, 4'd0, 4'd1);
    step();
    check("dir_div_rd", 64'(div_rd), 64'd5);
    for (int i = 1; i < LAT; i++) begin
      if (i == 1)      drive(1'b1, 4'b0010, 4'd9, 4'd5, 4'd1);
      else if (i == 2) drive(1'b1, 4'b0010, 4'd8, 4'd6, 4'd7);
      else             drive(1'b0, 4'b0010, 4'd10, 4'd11, 4'd12);
      step();
      if (i == 1) check("dir_raw_bubble", 64'(out_valid), 64'd0);
      if (i == 2) check("dir_indep_cap", 64'(out_rd), 64'd8);
      check("dir_busy_run", 64'(div_busy), 64'd1);
    end
    drive(1'b1, 4'b0001, 4'd9, 4'd2, 4'd3);
    step();
    check("dir_done_pulse", 64'(div_done), 64'd1);
    check("dir_div2_stalled", 64'(out_valid), 64'd0);
    step();
    check("dir_done_clear", 64'(div_done), 64'd0);
    check("dir_div2_rd", 64'(div_rd), 64'd9);

    // Reset in the middle of the second divide (counter at 4)
    drive(1'b0, 4'b0000, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 4; i++) step();
    do_reset();
    for (int i = 0; i < 6; i++) step();

    // Five stalled edges for the performance counter, then reset
    drive(1'b1, 4'b0001, 4'd7, 4'd0, 4'd1);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'b0010, 4'd2, 4'd7, 4'd3);
      step();
    end
`ifdef ID_EXE_PERF_EN
    check("dir_perf5", 64'(perf_stall_cnt), 64'd5);
`endif
    do_reset();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      wr_allow = ($urandom_range(0, 9) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      drive(1'($urandom_range(0, 3) != 0), UNIT_W'(1 << $urandom_range(0, 3)),
            REG_AW'($urandom_range(0, 5)), REG_AW'($urandom_range(0, 5)),
            REG_AW'($urandom_range(0, 5)));
      if ($urandom_range(0, 399) == 0) do_reset();
      else step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_reg_id_exe_trk.md
Name: pipe_reg_id_exe_trk

Overview:
Parametrised ID/EXE pipeline register with valid tracking, flush, and stall handling. Also contains an in-flight tracker for the multi-cycle divide unit, which covers destination register, busy countdown and done pulse. The tracker raises a stall request on structural (second divide) and RAW/WAW hazards against the outstanding divide. Sits between the decode/register-read stage and the execute units.

Parameters:
DATA_W, 32, width of operand data and immediate
REG_AW, 4, register index width
FLAGS_W, 6, control-flag vector width
UNIT_W, 4, execute-unit select width (one-hot)
DIV_BIT, 0, bit of unit select that marks the divide unit
DIV_LAT, 8, divide latency in cycles (valid range 2..255)

Ports:
clk  in  1  stage clock; all state updates on falling edge
rst  in  1  asynchronous, active-high reset
wr_allow  in  1  stage enable; low = hold all payload and valid
flush  in  1  squash the stage contents at the next edge
in_valid  in  1  decode presents an instruction
in_flags  in  FLAGS_W  control flags
in_rd, in_rs1, in_rs2  in  REG_AW each  destination and source indices
in_unit  in  UNIT_W  execute-unit select
in_d1, in_d2, in_imm  in  DATA_W each  operands and immediate
out_valid  out  1  stage holds a live instruction
out_flags, out_rd, out_rs1, out_rs2, out_unit, out_d1, out_d2, out_imm  out  as inputs  registered payload
stall_req  out  1  combinational; decode must hold its instruction
div_busy  out  1  divide outstanding
div_rd  out  REG_AW  destination of the outstanding divide
div_done  out  1  one-cycle pulse when the divide completes
perf_stall_cnt  out  16  stall counter (see Optional Feature)

Behaviour:
- Reset (async, rst=1): all payload outputs 0, out_valid=0, div counter=0, div_busy=0, div_rd=0, div_done=0, perf_stall_cnt=0.
- is_div = in_valid & in_unit[DIV_BIT].
- stall_req (combinational) = in_valid & div_busy & (is_div | in_rs1==div_rd | in_rs2==div_rd | in_rd==div_rd).
- Capture condition: cap = wr_allow & ~flush & ~stall_req.
- Per-edge priority:
  - flush: out_valid<=0; payload held.
  - else if ~wr_allow: hold everything.
  - else if stall_req: bubble, out_valid<=0; payload held.
  - else: load all payload; out_valid<=in_valid.
- Latency: payload visible 1 edge after capture.
- Divide tracker:
  - On cap & is_div: counter<=DIV_LAT, div_rd<=in_rd.
  - Otherwise, if counter!=0, counter decrements every edge regardless of wr_allow or flush.
  - div_busy = counter!=0.
  - div_done registered: high for exactly the cycle after the counter goes 1->0.
- A flush does not cancel an already-started divide. A divide squashed by flush at its capture edge never starts the tracker.
- When counter==1, div_busy is still high, so a new divide stalls and is captured at the following edge. Back-to-back divides are therefore spaced DIV_LAT+1 edges apart.
- div_rd holds its last value after completion. It is not compared while div_busy=0.
- Reset asserted mid-divide: tracker cleared immediately, and no div_done is produced.

Optional Feature:
- Macro: ID_EXE_PERF_EN.
- Defined: perf_stall_cnt counts the edges where wr_allow & ~flush & stall_req. The count saturates at 16'hFFFF and is cleared by rst.
- Undefined: no counter logic; perf_stall_cnt tied to 16'd0.

Test Plan:
- Reset then load in_valid=1, in_rd=3, in_d1=32'h1234, wr_allow=1 -> after 1 edge out_valid=1, out_rd=3, out_d1=32'h1234; stall_req=0.
- wr_allow=0 for 3 edges with changing inputs -> outputs unchanged; then flush=1 -> out_valid=0 and payload unchanged.
- Issue divide (unit=4'b0001, rd=5), DIV_LAT=8:
  - div_busy=1 and div_rd=5 for 8 cycles.
  - div_done high exactly on cycle 9 after capture, then 0.
- During that divide, present rs1=5 -> stall_req=1 and out_valid=0 bubble. Present rs1=6, rs2=7, rd=8, non-div -> stall_req=0 and the instruction is captured.
- Second divide presented while counter==1 -> stalled one edge, captured next. div_rd updates, and the first div_done still pulses.
- Assert rst during a divide at count 4 -> div_busy=0 at once and no div_done. With ID_EXE_PERF_EN, 5 stalled edges -> perf_stall_cnt=5, and rst -> 0.
